// File: rtl/spi_flash_resp_pkg.sv
// Shared types and constants for the SPI NOR flash responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_flash_resp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WDATA,
      ST_RDATA,
      ST_ID,
      ST_STATUS,
      ST_IGNORE
   } state_e;

   localparam logic [7:0] OP_RDID = 8'h9F;
   localparam logic [7:0] OP_RDSR = 8'h05;
   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_WRDI = 8'h04;
   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_PP   = 8'h02;

   // Status register bit positions
   localparam int SR_WIP = 0;
   localparam int SR_WEL = 1;

   // Address bytes that follow READ / PP
   localparam int ADDR_BYTES = 3;

endpackage

// File: rtl/spi_pin_sampler.sv
// Brings csn/sck/mosi into the system clock domain and derives edge strobes.
// Latency: two clocks of synchronizer delay; strobes are one-cycle pulses.
// Backpressure: none; the SPI master owns the pace.
module spi_pin_sampler (
   input  logic clock,
   input  logic rst,
   input  logic spi_csn,
   input  logic spi_sck,
   input  logic spi_mosi,
   output logic csn_hi,
   output logic csn_fall,
   output logic sck_rise,
   output logic sck_fall,
   output logic mosi
);

   logic [2:0] csn_q, csn_d;
   logic [2:0] sck_q, sck_d;
   logic [1:0] mosi_q, mosi_d;

   // Shift each pin through its synchronizer chain (bit 0 is the first stage)
   always_comb begin
      csn_d  = {csn_q[1:0], spi_csn};
      sck_d  = {sck_q[1:0], spi_sck};
      mosi_d = {mosi_q[0], spi_mosi};
   end

   // Synchronizer flops; csn resets high so no false select is seen after reset
   always_ff @(posedge clock) begin
      if (rst) begin
         csn_q  <= 3'b111;
         sck_q  <= 3'b000;
         mosi_q <= 2'b00;
      end else begin
         csn_q  <= csn_d;
         sck_q  <= sck_d;
         mosi_q <= mosi_d;
      end
   end

   assign csn_hi   = csn_q[1];
   assign csn_fall = csn_q[2] & ~csn_q[1];
   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign sck_fall = ~sck_q[1] & sck_q[2];
   assign mosi     = mosi_q[1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI NOR flash target: decodes RDID/RDSR/WREN/WRDI/READ/PP and drives an external SRAM.
// Latency: mem_re/mem_we one clock after the completing sck rise; read data loaded before the next fall.
// Backpressure: none; MISO is ready in time for any sck at most clock/4.
module spi_flash_responder
   import spi_flash_resp_pkg::*;
#(
   parameter int          ASIZE       = 24,
   parameter int          DSIZE       = 8,
   parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
   parameter int          PAGE_BITS   = 8,
   parameter int          PROG_CYCLES = 64
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             spi_csn,
   input  logic             spi_sck,
   input  logic [3:0]       spi_dq_i,
   output logic [3:0]       spi_dq_o,
   output logic [3:0]       spi_dq_oe,
   output logic [ASIZE-1:0] mem_addr,
   output logic [DSIZE-1:0] mem_wdata,
   output logic             mem_we,
   output logic             mem_re,
   input  logic [DSIZE-1:0] mem_rdata,
   output logic             wip,
   output logic             wel,
   output logic             cmd_err
);

   localparam int         BUSY_W   = $clog2(PROG_CYCLES + 1);
   localparam logic [2:0] LAST_BIT = 3'(DSIZE - 1);

   logic csn_hi, csn_fall, sck_rise, sck_fall, mosi;

   // Only IO0 is used in single-bit SPI mode
   wire unused_dq = ^spi_dq_i[3:1];

   spi_pin_sampler u_sampler (
      .clock    (clock),
      .rst      (rst),
      .spi_csn  (spi_csn),
      .spi_sck  (spi_sck),
      .spi_mosi (spi_dq_i[0]),
      .csn_hi   (csn_hi),
      .csn_fall (csn_fall),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .mosi     (mosi)
   );

   state_e             state_q, state_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic [DSIZE-2:0]   shift_q, shift_d;
   logic [DSIZE-1:0]   out_q, out_d;
   logic               miso_q, miso_d;
   logic               oe_q, oe_d;
   logic [ASIZE-1:0]   addr_q, addr_d;
   logic [1:0]         abyte_q, abyte_d;
   logic               is_pp_q, is_pp_d;
   logic [1:0]         id_idx_q, id_idx_d;
   logic               wrote_q, wrote_d;
   logic               wip_q, wip_d;
   logic               wel_q, wel_d;
   logic [BUSY_W-1:0]  busy_q, busy_d;
   logic               cmd_err_q, cmd_err_d;
   logic [ASIZE-1:0]   mem_addr_q, mem_addr_d;
   logic [DSIZE-1:0]   mem_wdata_q, mem_wdata_d;
   logic               mem_we_q, mem_we_d;
   logic               mem_re_q, mem_re_d;
   logic               rd_vld_q, rd_vld_d;

   logic [DSIZE-1:0]   rx_byte;
   logic [DSIZE-1:0]   tx_byte;
   logic [DSIZE-1:0]   status_byte;

   // Next-state logic: framing, command decode, SRAM strobes, busy timer and MISO
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      out_d       = out_q;
      miso_d      = miso_q;
      addr_d      = addr_q;
      abyte_d     = abyte_q;
      is_pp_d     = is_pp_q;
      id_idx_d    = id_idx_q;
      wrote_d     = wrote_q;
      wip_d       = wip_q;
      wel_d       = wel_q;
      busy_d      = busy_q;
      cmd_err_d   = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      mem_re_d    = 1'b0;
      rd_vld_d    = mem_re_q;

      rx_byte     = {shift_q, mosi};
      // SRAM data lands the cycle after mem_re; bypass it so a coincident fall sees it
      tx_byte     = rd_vld_q ? mem_rdata : out_q;
      status_byte = '0;
      status_byte[SR_WIP] = wip_q;
      status_byte[SR_WEL] = wel_q;

      if (wip_q) begin
         if (busy_q == BUSY_W'(1)) begin
            wip_d  = 1'b0;
            wel_d  = 1'b0;
            busy_d = '0;
         end else begin
            busy_d = busy_q - BUSY_W'(1);
         end
      end

      if (rd_vld_q) begin
         out_d = mem_rdata;
      end

      if (csn_hi) begin
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         shift_d   = '0;
         miso_d    = 1'b0;
         wrote_d   = 1'b0;
         if (state_q == ST_WDATA) begin
            if (wrote_q) begin
               wip_d  = 1'b1;
               busy_d = BUSY_W'(PROG_CYCLES);
            end else begin
               wel_d  = 1'b0;
            end
         end
      end else if (csn_fall) begin
         state_d   = ST_CMD;
         bit_cnt_d = '0;
         shift_d   = '0;
      end else begin
         if (sck_fall && (state_q == ST_ID || state_q == ST_STATUS || state_q == ST_RDATA)) begin
            miso_d = tx_byte[LAST_BIT - bit_cnt_q];
         end
         if (sck_rise && state_q != ST_IDLE) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = rx_byte[DSIZE-2:0];
            if (bit_cnt_q == LAST_BIT) begin
               case (state_q)
                  ST_CMD: begin
                     if (wip_q && rx_byte != OP_RDSR) begin
                        cmd_err_d = 1'b1;
                        state_d   = ST_IGNORE;
                     end else begin
                        case (rx_byte)
                           OP_RDID: begin
                              state_d  = ST_ID;
                              out_d    = JEDEC_ID[23:16];
                              id_idx_d = 2'd1;
                           end
                           OP_RDSR: begin
                              state_d = ST_STATUS;
                              out_d   = status_byte;
                           end
                           OP_WREN: begin
                              wel_d   = 1'b1;
                              state_d = ST_IGNORE;
                           end
                           OP_WRDI: begin
                              wel_d   = 1'b0;
                              state_d = ST_IGNORE;
                           end
                           OP_READ: begin
                              state_d = ST_ADDR;
                              is_pp_d = 1'b0;
                              abyte_d = '0;
                           end
                           OP_PP: begin
                              if (wel_q) begin
                                 state_d = ST_ADDR;
                                 is_pp_d = 1'b1;
                                 abyte_d = '0;
                              end else begin
                                 cmd_err_d = 1'b1;
                                 state_d   = ST_IGNORE;
                              end
                           end
                           default: begin
                              cmd_err_d = 1'b1;
                              state_d   = ST_IGNORE;
                           end
                        endcase
                     end
                  end
                  ST_ADDR: begin
                     addr_d  = {addr_q[ASIZE-DSIZE-1:0], rx_byte};
                     abyte_d = abyte_q + 2'd1;
                     if (abyte_q == 2'(ADDR_BYTES - 1)) begin
                        abyte_d = '0;
                        if (is_pp_q) begin
                           state_d = ST_WDATA;
                        end else begin
                           state_d    = ST_RDATA;
                           mem_re_d   = 1'b1;
                           mem_addr_d = {addr_q[ASIZE-DSIZE-1:0], rx_byte};
                        end
                     end
                  end
                  ST_WDATA: begin
                     mem_we_d    = 1'b1;
                     mem_wdata_d = rx_byte;
                     mem_addr_d  = addr_q;
                     wrote_d     = 1'b1;
                     // Offset wraps inside the page; page bits are untouched
                     addr_d[PAGE_BITS-1:0] = addr_q[PAGE_BITS-1:0] + PAGE_BITS'(1);
                  end
                  ST_RDATA: begin
                     addr_d     = addr_q + ASIZE'(1);
                     mem_addr_d = addr_q + ASIZE'(1);
                     mem_re_d   = 1'b1;
                  end
                  ST_ID: begin
                     case (id_idx_q)
                        2'd0:    out_d = JEDEC_ID[23:16];
                        2'd1:    out_d = JEDEC_ID[15:8];
                        default: out_d = JEDEC_ID[7:0];
                     endcase
                     id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                  end
                  ST_STATUS: begin
                     out_d = status_byte;
                  end
                  default: ;
               endcase
            end
         end
      end

      oe_d = !csn_hi && (state_d == ST_ID || state_d == ST_STATUS || state_d == ST_RDATA);
   end

   // State and registered outputs
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         out_q       <= '0;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
         addr_q      <= '0;
         abyte_q     <= '0;
         is_pp_q     <= 1'b0;
         id_idx_q    <= '0;
         wrote_q     <= 1'b0;
         wip_q       <= 1'b0;
         wel_q       <= 1'b0;
         busy_q      <= '0;
         cmd_err_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         rd_vld_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         out_q       <= out_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         addr_q      <= addr_d;
         abyte_q     <= abyte_d;
         is_pp_q     <= is_pp_d;
         id_idx_q    <= id_idx_d;
         wrote_q     <= wrote_d;
         wip_q       <= wip_d;
         wel_q       <= wel_d;
         busy_q      <= busy_d;
         cmd_err_q   <= cmd_err_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
         rd_vld_q    <= rd_vld_d;
      end
   end

   assign spi_dq_o  = {2'b00, miso_q, 1'b0};
   assign spi_dq_oe = {2'b00, oe_q, 1'b0};
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;
   assign wip       = wip_q;
   assign wel       = wel_q;
   assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder acting as SPI master plus SRAM model.
// Latency: SPI half period of 8 system clocks.
// Backpressure: none.
module tb_spi_flash_responder;

   localparam int HALF = 8;

   logic        clock = 1'b0;
   logic        rst;
   logic        spi_csn;
   logic        spi_sck;
   logic [3:0]  spi_dq_i;
   logic [3:0]  spi_dq_o;
   logic [3:0]  spi_dq_oe;
   logic [23:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata;
   logic        wip;
   logic        wel;
   logic        cmd_err;

   int checks   = 0;
   int failures = 0;

   // SRAM model and activity logs; only the monitor process writes these
   logic [7:0]  sram [logic [23:0]];
   logic        pre_we = 1'b0;
   logic [23:0] pre_addr = '0;
   logic [7:0]  pre_data = '0;
   int          we_cnt = 0, re_cnt = 0, err_cnt = 0, wip_cnt = 0;
   logic [23:0] we_addr_log[$];
   logic [7:0]  we_data_log[$];
   logic [23:0] re_addr_log[$];

   always #5 clock = ~clock;

   spi_flash_responder dut (
      .clock     (clock),
      .rst       (rst),
      .spi_csn   (spi_csn),
      .spi_sck   (spi_sck),
      .spi_dq_i  (spi_dq_i),
      .spi_dq_o  (spi_dq_o),
      .spi_dq_oe (spi_dq_oe),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata),
      .wip       (wip),
      .wel       (wel),
      .cmd_err   (cmd_err)
   );

   always @(posedge clock) begin
      if (pre_we) sram[pre_addr] = pre_data;
      if (mem_we === 1'b1) begin
         sram[mem_addr] = mem_wdata;
         we_addr_log.push_back(mem_addr);
         we_data_log.push_back(mem_wdata);
         we_cnt <= we_cnt + 1;
      end
      if (mem_re === 1'b1) begin
         mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : 8'h00;
         re_addr_log.push_back(mem_addr);
         re_cnt <= re_cnt + 1;
      end
      if (cmd_err === 1'b1) err_cnt <= err_cnt + 1;
      if (wip === 1'b1) wip_cnt <= wip_cnt + 1;
   end

   task automatic preload(input logic [23:0] a, input logic [7:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      @(negedge clock);
      pre_we   = 1'b0;
   endtask

   task automatic spi_begin();
      spi_csn = 1'b0;
      repeat (HALF) @(negedge clock);
   endtask

   task automatic spi_end();
      spi_sck     = 1'b0;
      spi_dq_i    = 4'h0;
      repeat (4) @(negedge clock);
      spi_csn     = 1'b1;
      repeat (16) @(negedge clock);
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < n; i++) begin
         spi_dq_i[0] = tx[7-i];
         repeat (HALF) @(negedge clock);
         rx[7-i] = spi_dq_o[1];
         spi_sck = 1'b1;
         repeat (HALF) @(negedge clock);
         spi_sck = 1'b0;
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      spi_bits(tx, 8, rx);
   endtask

   task automatic send_cmd(input logic [7:0] op);
      logic [7:0] rx;
      spi_begin();
      spi_byte(op, rx);
      spi_end();
   endtask

   task automatic test_reset();
      rst = 1'b1; spi_csn = 1'b1; spi_sck = 1'b0; spi_dq_i = 4'h0;
      repeat (3) @(negedge clock);
      checks++;
      if ({spi_dq_o, spi_dq_oe} !== 8'h00) begin
         failures++; $display("FAIL reset_pins: dq_o/dq_oe=%h expected 00", {spi_dq_o, spi_dq_oe});
      end
      checks++;
      if ({wip, wel, cmd_err, mem_we, mem_re} !== 5'b0) begin
         failures++; $display("FAIL reset_flags: wip,wel,err,we,re=%b expected 00000", {wip, wel, cmd_err, mem_we, mem_re});
      end
      checks++;
      if ({mem_addr, mem_wdata} !== 32'h0) begin
         failures++; $display("FAIL reset_mem_bus: addr/wdata=%h expected 0", {mem_addr, mem_wdata});
      end
      rst = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   task automatic test_jedec_id();
      logic [7:0] rx;
      logic [7:0] exp_id [4] = '{8'hEF, 8'h40, 8'h18, 8'hEF};
      int e0 = err_cnt;
      spi_begin();
      spi_byte(8'h9F, rx);
      for (int i = 0; i < 4; i++) begin
         spi_byte(8'h00, rx);
         checks++;
         if (rx !== exp_id[i]) begin
            failures++; $display("FAIL jedec_byte%0d: got %h expected %h", i, rx, exp_id[i]);
         end
      end
      checks++;
      if (spi_dq_oe !== 4'b0010) begin
         failures++; $display("FAIL jedec_oe: got %b expected 0010", spi_dq_oe);
      end
      spi_end();
      checks++;
      if (spi_dq_oe !== 4'b0000) begin
         failures++; $display("FAIL oe_after_csn: got %b expected 0000", spi_dq_oe);
      end
      checks++;
      if (err_cnt - e0 !== 0) begin
         failures++; $display("FAIL jedec_cmd_err: got %0d pulses expected 0", err_cnt - e0);
      end
   endtask

   task automatic test_wren_status();
      logic [7:0] rx;
      send_cmd(8'h06);
      checks++;
      if (wel !== 1'b1) begin
         failures++; $display("FAIL wren_wel: got %b expected 1", wel);
      end
      spi_begin();
      spi_byte(8'h05, rx);
      spi_byte(8'h00, rx);
      spi_end();
      checks++;
      if (rx !== 8'h02) begin
         failures++; $display("FAIL status_wel: got %h expected 02", rx);
      end
      send_cmd(8'h04);
      checks++;
      if (wel !== 1'b0) begin
         failures++; $display("FAIL wrdi_wel: got %b expected 0", wel);
      end
   endtask

   task automatic test_pp_no_wren();
      int e0 = err_cnt;
      int w0 = we_cnt;
      send_cmd(8'h02);
      checks++;
      if (err_cnt - e0 !== 1) begin
         failures++; $display("FAIL pp_nowren_err: got %0d pulses expected 1", err_cnt - e0);
      end
      checks++;
      if (we_cnt - w0 !== 0 || wel !== 1'b0) begin
         failures++; $display("FAIL pp_nowren_side: we=%0d wel=%b expected 0/0", we_cnt - w0, wel);
      end
   endtask

   task automatic test_page_program();
      logic [7:0]  rx;
      logic [23:0] exp_a [3] = '{24'h0001FE, 24'h0001FF, 24'h000100};
      logic [7:0]  exp_d [3] = '{8'hA1, 8'hB2, 8'hC3};
      int w0, p0;
      send_cmd(8'h06);
      w0 = we_cnt;
      spi_begin();
      spi_byte(8'h02, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h01, rx);
      spi_byte(8'hFE, rx);
      for (int i = 0; i < 3; i++) spi_byte(exp_d[i], rx);
      p0 = wip_cnt;
      spi_end();
      checks++;
      if (we_cnt - w0 !== 3) begin
         failures++; $display("FAIL pp_we_count: got %0d expected 3", we_cnt - w0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (we_addr_log[w0+i] !== exp_a[i] || we_data_log[w0+i] !== exp_d[i]) begin
               failures++; $display("FAIL pp_write%0d: got %h/%h expected %h/%h", i,
                  we_addr_log[w0+i], we_data_log[w0+i], exp_a[i], exp_d[i]);
            end
         end
      end
      checks++;
      if (wip !== 1'b1) begin
         failures++; $display("FAIL pp_wip_set: got %b expected 1", wip);
      end
      repeat (100) @(negedge clock);
      checks++;
      if (wip_cnt - p0 !== 64) begin
         failures++; $display("FAIL pp_wip_len: got %0d cycles expected 64", wip_cnt - p0);
      end
      spi_begin();
      spi_byte(8'h05, rx);
      spi_byte(8'h00, rx);
      spi_end();
      checks++;
      if (rx !== 8'h00 || wel !== 1'b0) begin
         failures++; $display("FAIL pp_status_after: got %h wel=%b expected 00 wel=0", rx, wel);
      end
   endtask

   task automatic test_pp_zero();
      logic [7:0] rx;
      int w0, p0;
      send_cmd(8'h06);
      w0 = we_cnt;
      p0 = wip_cnt;
      spi_begin();
      spi_byte(8'h02, rx);
      for (int i = 0; i < 3; i++) spi_byte(8'h00, rx);
      spi_end();
      repeat (20) @(negedge clock);
      checks++;
      if (wip_cnt - p0 !== 0 || we_cnt - w0 !== 0 || wel !== 1'b0) begin
         failures++; $display("FAIL pp_zero: wip_cycles=%0d we=%0d wel=%b expected 0/0/0",
            wip_cnt - p0, we_cnt - w0, wel);
      end
   endtask

   task automatic test_read_wrap();
      logic [7:0]  rx;
      logic [23:0] exp_a [4] = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
      logic [7:0]  exp_d [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
      int r0;
      for (int i = 0; i < 4; i++) preload(exp_a[i], exp_d[i]);
      r0 = re_cnt;
      spi_begin();
      spi_byte(8'h03, rx);
      spi_byte(8'hFF, rx);
      spi_byte(8'hFF, rx);
      spi_byte(8'hFE, rx);
      for (int i = 0; i < 4; i++) begin
         spi_byte(8'h00, rx);
         checks++;
         if (rx !== exp_d[i]) begin
            failures++; $display("FAIL read_byte%0d: got %h expected %h", i, rx, exp_d[i]);
         end
      end
      spi_end();
      checks++;
      if (re_cnt - r0 < 4) begin
         failures++; $display("FAIL read_re_count: got %0d expected >=4", re_cnt - r0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (re_addr_log[r0+i] !== exp_a[i]) begin
               failures++; $display("FAIL read_addr%0d: got %h expected %h", i, re_addr_log[r0+i], exp_a[i]);
            end
         end
      end
   endtask

   task automatic test_abort();
      logic [7:0] rx;
      int r0 = re_cnt;
      int w0 = we_cnt;
      spi_begin();
      spi_byte(8'h03, rx);
      spi_bits(8'h12, 5, rx);
      spi_end();
      checks++;
      if (re_cnt - r0 !== 0 || we_cnt - w0 !== 0 || spi_dq_oe !== 4'b0000) begin
         failures++; $display("FAIL abort_side: re=%0d we=%0d oe=%b expected 0/0/0000",
            re_cnt - r0, we_cnt - w0, spi_dq_oe);
      end
      spi_begin();
      spi_byte(8'h05, rx);
      spi_byte(8'h00, rx);
      spi_end();
      checks++;
      if (rx !== 8'h00) begin
         failures++; $display("FAIL abort_status: got %h expected 00", rx);
      end
   endtask

   task automatic test_rst_during_wip();
      logic [7:0] rx;
      send_cmd(8'h06);
      spi_begin();
      spi_byte(8'h02, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h10, rx);
      spi_byte(8'h55, rx);
      spi_end();
      checks++;
      if (wip !== 1'b1) begin
         failures++; $display("FAIL rst_wip_pre: got %b expected 1", wip);
      end
      rst = 1'b1;
      @(negedge clock);
      checks++;
      if (wip !== 1'b0 || wel !== 1'b0) begin
         failures++; $display("FAIL rst_wip_abort: wip=%b wel=%b expected 0/0", wip, wel);
      end
      rst = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_jedec_id();
      test_wren_status();
      test_pp_no_wren();
      test_page_program();
      test_pp_zero();
      test_read_wrap();
      test_abort();
      test_rst_during_wip();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI NOR flash target: the device end of the link driven by our SPI flash master. Used as an on-chip flash model for loopback benches and FPGA self-test.
- Decodes serial commands and answers them:
  - JEDEC ID read
  - write enable / write disable
  - read status
  - page program
  - read data
- Storage is an external single-port SRAM with 1-cycle read latency; this block generates the SRAM accesses.
- All SPI pins are oversampled in the system clock domain; the block does not clock on spi_sck.

Parameters:
- ASIZE, 24, byte-address width sent after the opcode (3 bytes).
- DSIZE, 8, data/opcode byte width.
- JEDEC_ID, 24'hEF4018, ID bytes returned MSB first by 0x9F.
- PAGE_BITS, 8, page size is 2^PAGE_BITS bytes; sets program-address wrap.
- PROG_CYCLES, 64, clock cycles WIP stays high after a valid program ends.

Ports:
- clock, in, 1, system clock; frequency must be at least 4x spi_sck.
- rst, in, 1, synchronous active-high reset.
- spi_csn, in, 1, chip select, active low.
- spi_sck, in, 1, SPI clock, mode 0 (idle low).
- spi_dq_i, in, 4, pad inputs; bit0 = IO0/MOSI.
- spi_dq_o, out, 4, pad outputs; bit1 = IO1/MISO.
- spi_dq_oe, out, 4, pad output enables.
- mem_addr, out, ASIZE, SRAM byte address.
- mem_wdata, out, DSIZE, SRAM write data.
- mem_we, out, 1, SRAM write strobe, single cycle.
- mem_re, out, 1, SRAM read strobe, single cycle; mem_rdata is valid on the next clock.
- mem_rdata, in, DSIZE, SRAM read data.
- wip, out, 1, status bit0 (write in progress).
- wel, out, 1, status bit1 (write enable latch).
- cmd_err, out, 1, one-cycle pulse when an opcode is rejected.

Behaviour:
- Input sampling:
  - spi_csn, spi_sck and spi_dq_i[0] each pass through a 2-flop synchronizer.
  - A third flop on sck gives the rise and fall strobes.
- Bit timing:
  - MOSI is shifted in MSB first on each sck rise strobe.
  - MISO is updated on each sck fall strobe.
  - spi_dq_oe = 4'b0010 only in the ID, STATUS and RDATA states while csn is low; otherwise 0.
  - spi_dq_o[1] holds the current output bit; the other spi_dq_o bits are 0.
- Bit counter: a 3-bit counter advances on each rise strobe and wraps at 8. A byte is complete when it wraps.
- csn framing:
  - The csn falling edge resets the bit counter and the shift register and enters CMD.
  - csn high at any time forces IDLE on the next clock. Any partial byte is discarded and dq_oe drops.
- State machine (IDLE, CMD, ADDR, WDATA, RDATA, ID, STATUS, IGNORE), decided on the first complete byte in CMD:
  - 0x9F → ID: shift out JEDEC_ID bytes MSB first, then repeat them.
  - 0x05 → STATUS: output {6'b0, wel, wip}, repeated for every byte.
  - 0x06 → set wel, go to IGNORE. 0x04 → clear wel, go to IGNORE.
  - 0x03 → ADDR (3 bytes), then RDATA.
  - 0x02 → ADDR, then WDATA, only if wel=1. If wel=0: pulse cmd_err, go to IGNORE.
  - Any other opcode → pulse cmd_err, go to IGNORE.
  - While wip=1, every opcode except 0x05 → cmd_err pulse, go to IGNORE.
- Read path (RDATA):
  - mem_re pulses at the rise strobe that completes the last address byte, with mem_addr = address.
  - The returned byte is loaded into the output shifter before the next fall strobe.
  - At each byte completion the address increments modulo 2^ASIZE and the next byte is prefetched.
- Program path (WDATA):
  - Each complete byte gives a one-cycle mem_we with mem_wdata = byte and mem_addr = {addr[ASIZE-1:PAGE_BITS], offset}.
  - offset increments and wraps within the page (256-byte page: 0xFF → 0x00).
- End of program:
  - On csn high after WDATA with at least one byte written: wip=1 for exactly PROG_CYCLES clocks, then wip=0 and wel=0.
  - Zero data bytes: no wip, and wel is still cleared.
- Reset values:
  - State IDLE; wip=0, wel=0, cmd_err=0.
  - mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
  - spi_dq_o=0, spi_dq_oe=0.
- rst during a program cycle aborts the busy timer; wip=0.

Decomposition:
- Package spi_flash_resp_pkg holds:
  - the state enum;
  - opcode localparams OP_RDID=8'h9F, OP_RDSR=8'h05, OP_WREN=8'h06, OP_WRDI=8'h04, OP_READ=8'h03, OP_PP=8'h02;
  - status bit indices.
- Sub-module spi_pin_sampler: synchronizers plus rise/fall/csn-fall strobes. The remaining logic stays in the top block.

Test Plan:
- Send 0x9F, then clock 32 bits → MISO returns EF 40 18 EF; cmd_err=0.
- Send 0x06, raise csn, then 0x05 and read 1 byte → 0x02; wel=1.
- Without WREN, send 0x02 → cmd_err pulses once, no mem_we, wel stays 0.
- WREN, then PP at 0x0001FE with A1 B2 C3 → mem_we at addresses 0x0001FE, 0x0001FF, 0x000100 (page wrap). After csn rise, wip=1 for 64 clocks, then status reads 0x00.
- SRAM preloaded 0x10..0x13 at 0xFFFFFE.. wrapping; READ 0x03 at 0xFFFFFE, 4 bytes → 10 11 12 13 from addresses FFFFFE, FFFFFF, 000000, 000001.
- Raise csn after 5 bits of an address byte, then issue 0x05 → state returns to IDLE, no mem access, status reads correctly. Assert rst during wip → wip=0 on the next clock.
